fifo_enq_arbiter: RTL
=====================

Name: fifo_enq_arbiter

Overview:
Round-robin arbiter that shares the enqueue port of one fifo instance between N_REQ requesters, each with its own ready/valid interface. It supports optional multi-beat locking so one requester can enqueue a contiguous run of entries. Lock length is capped by MAX_LOCK_BEATS to bound starvation of the other requesters. It sits directly in front of the fifo enqueue side: fifo_enq_valid/fifo_enq_data drive the fifo's enq_valid/enq_data, and the fifo's enq_ready drives fifo_enq_ready.

Parameters:
N_REQ, 4, number of requesters (>=2; need not be a power of two)
ENTRY_WIDTH, 32, payload width; must match the downstream fifo's entry width
MAX_LOCK_BEATS, 4, max transfers per lock tenure (>=1)
ID_WIDTH (local), $clog2(N_REQ), width of the grant id and rr pointer
BEAT_WIDTH (local), $clog2(MAX_LOCK_BEATS+1), width of the lock beat counter

Ports:
clk  in  1  clock
rst_aH  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester valid
req_ready  out  N_REQ  per-requester ready (one-hot or zero)
req_lock  in  N_REQ  requester asks to keep the grant after this beat
req_data  in  N_REQ x ENTRY_WIDTH  per-requester payload
fifo_enq_valid  out  1  to fifo enq_valid
fifo_enq_ready  in  1  from fifo enq_ready
fifo_enq_data  out  ENTRY_WIDTH  to fifo enq_data
grant_id  out  ID_WIDTH  index currently selected; valid only when fifo_enq_valid=1
locked  out  1  state==LOCKED (debug)
init  in  1  test preload, synchronous, overrides all state updates
init_rr_ptr  in  ID_WIDTH  preload value for rr_ptr (state->IDLE, beats->0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_aH is asynchronous and active-high.
- State registers: rr_ptr (ID_WIDTH), state {IDLE, LOCKED}, owner (ID_WIDTH), beats (BEAT_WIDTH).
- Reset values: rr_ptr=0, state=IDLE, owner=0, beats=0.
- Outputs while rst_aH=1: fifo_enq_valid=0, req_ready=0, locked=0.
- Selection (combinational, zero latency):
  - IDLE: grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap at N_REQ-1 -> 0.
  - LOCKED: only owner is eligible; all other requesters see req_ready=0.
- Output assignments:
  - fifo_enq_valid = eligible requester exists.
  - fifo_enq_data = req_data[grant_id].
  - req_ready[i] = fifo_enq_ready & fifo_enq_valid & (grant_id==i).
- Transfer definition: xfer = fifo_enq_valid & fifo_enq_ready. No state changes without xfer, so the grant is stable while the fifo is full.
- Requester contract: once valid is asserted it holds valid and data until ready. Arbiter contract: grant_id does not change while fifo_enq_ready=0 and valids are held.
- On xfer in IDLE:
  - If req_lock[grant_id]=0 or MAX_LOCK_BEATS==1: rr_ptr <= (grant_id+1) mod N_REQ; stay IDLE.
  - Otherwise: state <= LOCKED, owner <= grant_id, beats <= 1; rr_ptr unchanged.
- On xfer in LOCKED:
  - If req_lock[owner]=0 or beats+1==MAX_LOCK_BEATS: state <= IDLE, beats <= 0, rr_ptr <= (owner+1) mod N_REQ. This is a forced release at the cap.
  - Otherwise: beats <= beats+1.
- LOCKED with owner valid low: fifo_enq_valid=0 and the arbiter stays LOCKED; the other requesters wait. Owner is responsible for dropping the lock.
- Wrap arithmetic: mod N_REQ is an explicit compare-to-(N_REQ-1) and clear, not a bit-truncation, so non-power-of-two N_REQ works.
- Reset asserted mid-lock: returns to IDLE immediately; no partial beat is committed.
- init=1 has priority over xfer in the same cycle.

Decomposition:
- Shared package: arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module rr_pick: combinational rotating priority picker, inputs valid[N] and ptr, outputs any, idx, onehot. Built from the existing dec_/mux_ primitives with a doubled-vector scan.
- The top level holds the state registers (reg_ instances) and the output muxing.

Test Plan:
1. N_REQ=4, all valid, no lock, fifo_enq_ready=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles; exactly one req_ready high per cycle.
2. Only req2 valid, fifo_enq_ready=0 for 3 cycles -> fifo_enq_valid=1, grant_id=2, req_ready=0000, rr_ptr stays 0. Ready rises -> one xfer, then rr_ptr=3.
3. All valid, req1 lock=1 held for 6 beats, MAX_LOCK_BEATS=4, rr_ptr=1 -> grants 1,1,1,1 (locked=1 during beats 1-3), forced release, next grant 2.
4. Locked on owner 0, req0 valid drops while req3 valid -> fifo_enq_valid=0, req_ready=0000, locked=1. req0 returns with lock=0 -> one xfer, IDLE, next grant 3.
5. rst_aH pulsed during a LOCKED tenure owned by 2 -> outputs zero during reset; after reset locked=0, rr_ptr=0, and with req2 and req3 valid the grant is 2.
6. N_REQ=3, init_rr_ptr=2, only req0 valid -> grant_id=0; after xfer rr_ptr=1. Separately, from grant 2 the pointer wraps to 0.

Source files
------------

// File: rtl/fifo_enq_arbiter_pkg.sv
// Shared types for the fifo enqueue arbiter.
package fifo_enq_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// Rotating-priority picker: the first valid at or after ptr, wrapping at N-1.
// The valid vector is doubled so a plain upward scan from ptr covers the wrap.
module rr_pick
  import fifo_enq_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [2*N-1:0] dbl;
  logic [IW:0]    ptr_c;
  logic [IW:0]    pos;

  // Scan the doubled vector from ptr; an out-of-range ptr falls back to 0.
  always_comb begin
    dbl    = {valid, valid};
    ptr_c  = ({1'b0, ptr} >= (IW+1)'(N)) ? '0 : {1'b0, ptr};
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      pos = ptr_c + (IW+1)'(k);
      if (!any && dbl[pos]) begin
        any = 1'b1;
        idx = (pos >= (IW+1)'(N)) ? IW'(pos - (IW+1)'(N)) : IW'(pos);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one fifo enqueue port between N_REQ requesters,
// with optional multi-beat locking capped at MAX_LOCK_BEATS transfers.
//
// state      | meaning
// ARB_IDLE   | rotating pick among all valid requesters, starting at rr_ptr
// ARB_LOCKED | only owner may enqueue; beats counts transfers in this tenure
module fifo_enq_arbiter
  import fifo_enq_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ENTRY_WIDTH    = 32,
  parameter int MAX_LOCK_BEATS = 4,
  localparam int ID_WIDTH      = $clog2(N_REQ),
  localparam int BEAT_WIDTH    = $clog2(MAX_LOCK_BEATS + 1)
) (
  input  logic                                clk,
  input  logic                                rst_aH,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0]                    req_lock,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]   req_data,
  output logic                                fifo_enq_valid,
  input  logic                                fifo_enq_ready,
  output logic [ENTRY_WIDTH-1:0]              fifo_enq_data,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic                                locked,
  input  logic                                init,
  input  logic [ID_WIDTH-1:0]                 init_rr_ptr
);

  arb_state_t            state, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0]   owner, owner_nxt;
  logic [BEAT_WIDTH-1:0] beats, beats_nxt;

  logic                  pick_any;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [N_REQ-1:0]      pick_onehot;
  logic [N_REQ-1:0]      grant_onehot;
  logic [ID_WIDTH-1:0]   grant_next;
  logic                  eligible;
  logic                  xfer;

  rr_pick #(.N(N_REQ), .IW(ID_WIDTH)) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign locked = (state == ARB_LOCKED);

  // Grant selection and fifo-side outputs; everything is gated off in reset.
  always_comb begin
    eligible     = 1'b0;
    grant_id     = pick_idx;
    grant_onehot = pick_onehot;
    if (locked) begin
      eligible     = req_valid[owner];
      grant_id     = owner;
      grant_onehot = N_REQ'(1) << owner;
    end else begin
      eligible     = pick_any;
    end
    fifo_enq_valid = eligible & ~rst_aH;
    fifo_enq_data  = req_data[grant_id];
    xfer           = fifo_enq_valid & fifo_enq_ready;
    req_ready      = xfer ? grant_onehot : '0;
    // Explicit wrap so non-power-of-two N_REQ rotates correctly.
    grant_next     = (grant_id == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
  end

  // Next-state: only a transfer (or the init preload) moves the state.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    beats_nxt  = beats;
    if (init) begin
      state_nxt  = ARB_IDLE;
      rr_ptr_nxt = init_rr_ptr;
      beats_nxt  = '0;
    end else if (xfer) begin
      case (state)
        ARB_IDLE: begin
          if (!req_lock[grant_id] || (MAX_LOCK_BEATS == 1)) begin
            rr_ptr_nxt = grant_next;
          end else begin
            state_nxt = ARB_LOCKED;
            owner_nxt = grant_id;
            beats_nxt = BEAT_WIDTH'(1);
          end
        end
        ARB_LOCKED: begin
          if (!req_lock[owner] ||
              (beats + BEAT_WIDTH'(1) == BEAT_WIDTH'(MAX_LOCK_BEATS))) begin
            state_nxt  = ARB_IDLE;
            beats_nxt  = '0;
            rr_ptr_nxt = grant_next;
          end else begin
            beats_nxt = beats + BEAT_WIDTH'(1);
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      beats  <= beats_nxt;
    end
  end

endmodule
